fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/fetch_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcode field and HALT constant.
// Imported by the fetch unit and downstream pipeline stages.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;

  localparam opcode_t HALT = 6'h3F;

  function automatic opcode_t opcode_of(input word_t w);
    return w[31:26];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, stall hold buffer, redirect
// and halt handling; outputs feed the IF/ID register directly.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t iload,
  input  logic  stall,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  output logic  iREN,
  output word_t iaddr,
  output logic  fetch_op_valid,
  output word_t fetch_op_npc,
  output word_t fetch_op_imemload,
  output logic  halted
);

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    HALTED
  } state_t;

  state_t state;
  state_t state_nx;
  word_t  pc;
  word_t  pc_nx;
  word_t  pc_plus4;
  word_t  hold_word;
  word_t  hold_word_nx;
  word_t  hold_npc;
  word_t  hold_npc_nx;
  logic   valid_c;

  assign pc_plus4 = pc + 32'd4;
  assign iaddr    = pc;

  // never present an instruction while reset is asserted
  assign fetch_op_valid = valid_c & ~RST;

  // state, PC and hold buffer registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      pc        <= PC_INIT;
      hold_word <= '0;
      hold_npc  <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      hold_word <= hold_word_nx;
      hold_npc  <= hold_npc_nx;
    end
  end

  // next-state, PC update and output selection
  always_comb begin
    state_nx          = state;
    pc_nx             = pc;
    hold_word_nx      = hold_word;
    hold_npc_nx       = hold_npc;
    iREN              = 1'b0;
    valid_c           = 1'b0;
    halted            = 1'b0;
    fetch_op_npc      = hold_npc;
    fetch_op_imemload = hold_word;

    unique case (state)
      RUN: begin
        iREN              = 1'b1;
        fetch_op_npc      = pc_plus4;
        fetch_op_imemload = iload;
        if (redirect_valid) begin
          pc_nx        = redirect_pc;
          hold_word_nx = '0;
          hold_npc_nx  = '0;
        end else if (ihit && !stall) begin
          valid_c      = 1'b1;
          pc_nx        = pc_plus4;
          // keep a copy so the outputs stay put if this is a halt
          hold_word_nx = iload;
          hold_npc_nx  = pc_plus4;
          if (opcode_of(iload) == HALT) state_nx = HALTED;
        end else if (ihit) begin
          hold_word_nx = iload;
          hold_npc_nx  = pc_plus4;
          state_nx     = HOLD;
        end
      end
      HOLD: begin
        valid_c = !stall && !redirect_valid;
        if (redirect_valid) begin
          pc_nx        = redirect_pc;
          hold_word_nx = '0;
          hold_npc_nx  = '0;
          state_nx     = RUN;
        end else if (!stall) begin
          pc_nx    = hold_npc;
          state_nx = (opcode_of(hold_word) == HALT) ? HALTED : RUN;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (redirect_valid) begin
          pc_nx        = redirect_pc;
          hold_word_nx = '0;
          hold_npc_nx  = '0;
          state_nx     = RUN;
        end
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

endmodule
